// File: rtl/des_pkg.sv
// DES tables, S-boxes, the decrypt key-rotation schedule and the shared
// bit-permutation helper used by the iterative decryptor.
package des_pkg;

  typedef enum logic [1:0] {IDLE, ROUND, DONE} state_e;
  typedef enum logic [2:0] {PERM_IP, PERM_FP, PERM_E, PERM_P, PERM_PC1, PERM_PC2} perm_e;

  localparam int unsigned ROUNDS = 16;

  localparam byte unsigned IP_TBL [0:63] = '{
    58, 50, 42, 34, 26, 18, 10,  2, 60, 52, 44, 36, 28, 20, 12,  4,
    62, 54, 46, 38, 30, 22, 14,  6, 64, 56, 48, 40, 32, 24, 16,  8,
    57, 49, 41, 33, 25, 17,  9,  1, 59, 51, 43, 35, 27, 19, 11,  3,
    61, 53, 45, 37, 29, 21, 13,  5, 63, 55, 47, 39, 31, 23, 15,  7};

  localparam byte unsigned FP_TBL [0:63] = '{
    40,  8, 48, 16, 56, 24, 64, 32, 39,  7, 47, 15, 55, 23, 63, 31,
    38,  6, 46, 14, 54, 22, 62, 30, 37,  5, 45, 13, 53, 21, 61, 29,
    36,  4, 44, 12, 52, 20, 60, 28, 35,  3, 43, 11, 51, 19, 59, 27,
    34,  2, 42, 10, 50, 18, 58, 26, 33,  1, 41,  9, 49, 17, 57, 25};

  localparam byte unsigned E_TBL [0:47] = '{
    32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
     8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
    24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};

  localparam byte unsigned P_TBL [0:31] = '{
    16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};

  localparam byte unsigned PC1_TBL [0:55] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};

  localparam byte unsigned PC2_TBL [0:47] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

  // Right rotation applied before round n (entry n-1); K16 equals PC1(key) so round 1 needs none.
  localparam logic [1:0] DEC_SHIFT [0:15] = '{
    2'd0, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1};

  // Indexed [box][row*16 + col].
  localparam logic [3:0] SBOX_TBL [0:7][0:63] = '{
    '{14, 4,13, 1, 2,15,11, 8, 3,10, 6,12, 5, 9, 0, 7,
       0,15, 7, 4,14, 2,13, 1,10, 6,12,11, 9, 5, 3, 8,
       4, 1,14, 8,13, 6, 2,11,15,12, 9, 7, 3,10, 5, 0,
      15,12, 8, 2, 4, 9, 1, 7, 5,11, 3,14,10, 0, 6,13},
    '{15, 1, 8,14, 6,11, 3, 4, 9, 7, 2,13,12, 0, 5,10,
       3,13, 4, 7,15, 2, 8,14,12, 0, 1,10, 6, 9,11, 5,
       0,14, 7,11,10, 4,13, 1, 5, 8,12, 6, 9, 3, 2,15,
      13, 8,10, 1, 3,15, 4, 2,11, 6, 7,12, 0, 5,14, 9},
    '{10, 0, 9,14, 6, 3,15, 5, 1,13,12, 7,11, 4, 2, 8,
      13, 7, 0, 9, 3, 4, 6,10, 2, 8, 5,14,12,11,15, 1,
      13, 6, 4, 9, 8,15, 3, 0,11, 1, 2,12, 5,10,14, 7,
       1,10,13, 0, 6, 9, 8, 7, 4,15,14, 3,11, 5, 2,12},
    '{ 7,13,14, 3, 0, 6, 9,10, 1, 2, 8, 5,11,12, 4,15,
      13, 8,11, 5, 6,15, 0, 3, 4, 7, 2,12, 1,10,14, 9,
      10, 6, 9, 0,12,11, 7,13,15, 1, 3,14, 5, 2, 8, 4,
       3,15, 0, 6,10, 1,13, 8, 9, 4, 5,11,12, 7, 2,14},
    '{ 2,12, 4, 1, 7,10,11, 6, 8, 5, 3,15,13, 0,14, 9,
      14,11, 2,12, 4, 7,13, 1, 5, 0,15,10, 3, 9, 8, 6,
       4, 2, 1,11,10,13, 7, 8,15, 9,12, 5, 6, 3, 0,14,
      11, 8,12, 7, 1,14, 2,13, 6,15, 0, 9,10, 4, 5, 3},
    '{12, 1,10,15, 9, 2, 6, 8, 0,13, 3, 4,14, 7, 5,11,
      10,15, 4, 2, 7,12, 9, 5, 6, 1,13,14, 0,11, 3, 8,
       9,14,15, 5, 2, 8,12, 3, 7, 0, 4,10, 1,13,11, 6,
       4, 3, 2,12, 9, 5,15,10,11,14, 1, 7, 6, 0, 8,13},
    '{ 4,11, 2,14,15, 0, 8,13, 3,12, 9, 7, 5,10, 6, 1,
      13, 0,11, 7, 4, 9, 1,10,14, 3, 5,12, 2,15, 8, 6,
       1, 4,11,13,12, 3, 7,14,10,15, 6, 8, 0, 5, 9, 2,
       6,11,13, 8, 1, 4,10, 7, 9, 5, 0,15,14, 2, 3,12},
    '{13, 2, 8, 4, 6,15,11, 1,10, 9, 3,14, 5, 0,12, 7,
       1,15,13, 8,10, 3, 7, 4,12, 5, 6,11, 0,14, 9, 2,
       7,11, 4, 1, 9,12,14, 2, 0, 6,10,13,15, 3, 5, 8,
       2, 1,14, 7, 4,10, 8,13,15,12, 9, 0, 3, 5, 6,11}};

  function automatic int perm_width(input perm_e which);
    case (which)
      PERM_IP, PERM_FP: return 64;
      PERM_E, PERM_PC2: return 48;
      PERM_P:           return 32;
      default:          return 56;
    endcase
  endfunction

  function automatic int tbl_at(input perm_e which, input logic [5:0] idx);
    case (which)
      PERM_IP:  return int'(IP_TBL[idx]);
      PERM_FP:  return int'(FP_TBL[idx]);
      PERM_E:   return int'(E_TBL[idx]);
      PERM_P:   return int'(P_TBL[idx[4:0]]);
      PERM_PC1: return int'(PC1_TBL[idx]);
      default:  return int'(PC2_TBL[idx]);
    endcase
  endfunction

  // Source and result are right-aligned in 64 bits; DES bit i of a W-bit vector is bit W-i.
  function automatic logic [63:0] permute(input logic [63:0] src, input int src_w, input perm_e which);
    int          dst_w;
    logic [63:0] res;
    dst_w = perm_width(which);
    res   = '0;
    for (int i = 0; i < 64; i++) begin
      if (i < dst_w) res[6'(dst_w - 1 - i)] = src[6'(src_w - tbl_at(which, 6'(i)))];
    end
    return res;
  endfunction

endpackage

// File: rtl/des_round_f.sv
// Combinational DES round function f(R, K) = P(S(E(R) ^ K)); shareable with an encryptor.
module des_round_f
  import des_pkg::*;
(
  input  logic [31:0] r,
  input  logic [47:0] k,
  output logic [31:0] f
);

  logic [47:0] xor_result;
  logic [31:0] sbox_out;

  assign xor_result = 48'(permute({32'b0, r}, 32, PERM_E)) ^ k;

  sbox_array u_sbox (
    .xor_result(xor_result),
    .sbox_out  (sbox_out)
  );

  assign f = 32'(permute({32'b0, sbox_out}, 32, PERM_P));

endmodule

// File: rtl/sbox_array.sv
// The eight DES S-boxes side by side: 48-bit xor result in, 32-bit substitution out.
module sbox_array
  import des_pkg::*;
(
  input  logic [47:0] xor_result,
  output logic [31:0] sbox_out
);

  // Group g (S1 at the top) uses its outer bits as row and inner four bits as column.
  for (genvar g = 0; g < 8; g++) begin : g_box
    logic [5:0] grp;
    assign grp = xor_result[47-6*g -: 6];
    assign sbox_out[31-4*g -: 4] = SBOX_TBL[g][{grp[5], grp[0], grp[4:1]}];
  end

endmodule

// File: rtl/des_decrypt_iter.sv
// Iterative DES decryptor: one Feistel round per clock, key schedule walked
// backwards with right rotations, valid/ready on both sides, one block in flight.
module des_decrypt_iter
  import des_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] ciphertext,
  input  logic [63:0] key,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] plaintext,
  output logic        busy
);

  state_e      state, state_next;
  logic [31:0] l_half, r_half;
  logic [55:0] cd;
  logic [4:0]  rnd;

  logic        accept, last_round;
  logic [1:0]  shift;
  logic [55:0] cd_init, cd_next;
  logic [47:0] subkey;
  logic [31:0] f_out, l_new, r_new;
  logic [63:0] ip_block, final_block;

  function automatic logic [27:0] rotr28(input logic [27:0] x, input logic [1:0] n);
    case (n)
      2'd0:    return x;
      2'd1:    return {x[0], x[27:1]};
      default: return {x[1:0], x[27:2]};
    endcase
  endfunction

  assign accept     = in_valid && in_ready;
  assign last_round = (rnd == 5'(ROUNDS));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    // NOTE: default assignment first so no path leaves state_next unassigned (no latch).
    state_next = state;
    case (state)
      IDLE:    if (accept)     state_next = ROUND;
      ROUND:   if (last_round) state_next = DONE;
      DONE:    if (out_ready)  state_next = IDLE;
      default:                 state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    busy      = (state != IDLE);
  end

  assign ip_block = permute(ciphertext, 64, PERM_IP);
  assign cd_init  = 56'(permute(key, 64, PERM_PC1));

  assign shift   = DEC_SHIFT[4'(rnd - 5'd1)];
  assign cd_next = {rotr28(cd[55:28], shift), rotr28(cd[27:0], shift)};
  assign subkey  = 48'(permute({8'b0, cd_next}, 56, PERM_PC2));

  des_round_f u_round_f (
    .r(r_half),
    .k(subkey),
    .f(f_out)
  );

  assign l_new = r_half;
  assign r_new = l_half ^ f_out;
  // The last round's halves are swapped back before FP: R16 forms the upper half.
  assign final_block = permute({r_new, l_new}, 64, PERM_FP);

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      l_half    <= '0;
      r_half    <= '0;
      cd        <= '0;
      rnd       <= '0;
      plaintext <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            {l_half, r_half} <= ip_block;
            cd               <= cd_init;
            rnd              <= 5'd1;
          end
        end
        ROUND: begin
          l_half <= l_new;
          r_half <= r_new;
          cd     <= cd_next;
          if (last_round) plaintext <= final_block;
          else            rnd       <= rnd + 5'd1;
        end
        default: ;
      endcase
    end
  end

endmodule
